switchbox_cfg_loader: RTL and testbench
=======================================

Name: switchbox_cfg_loader

Overview:
- Serial configuration writer for the 4x8 switch-box routing matrix.
- Receives a bit-serial route stream and deserializes it into one 6-bit route word per switch-box pin.
- Validates each word, then commits the full set atomically onto a flattened configuration bus that drives the matrix's per-pin select registers.
- Sits between the device configuration controller and the routing fabric.

Parameters:
- N_TB, 5, pins on top side and on bottom side
- N_LR, 4, pins on left side and on right side
- CFG_W, 6, route word width: [2:0] side code, [5:3] source index
- N_ENT, 2*N_TB+2*N_LR (18), total route words per load (derived; do not override)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  synchronous active-low reset
- cfg_start  in  1  pulse; begins a new load and discards any partial load
- cfg_valid  in  1  cfg_bit qualifier
- cfg_bit  in  1  serial data, MSB of each word first
- cfg_ready  out  1  high while loader accepts bits
- cfg_out  out  N_ENT*CFG_W  active config; entry k at [k*CFG_W +: CFG_W]
- cfg_done  out  1  one-cycle pulse on successful commit
- cfg_err  out  1  sticky load error
- err_word  out  5  entry index of the first failing word
- busy  out  1  high in any state other than IDLE

Behaviour:
- Entry order k:
  - 0..4 = top[0..4]
  - 5..9 = bottom[0..4]
  - 10..13 = left[0..3]
  - 14..17 = right[0..3]
- Side code values:
  - 0 = undriven (high-Z)
  - 1 = top, 2 = right, 3 = bottom, 4 = left
  - 5..7 are illegal
- Reset (rst_n low at an edge):
  - State goes to IDLE.
  - cfg_out = all zeros (every pin high-Z); the shadow register is also cleared.
  - cfg_ready, cfg_done, cfg_err, busy = 0; err_word = 0.
  - Reset mid-load discards everything, including the previously committed config.
- FSM states: IDLE, SHIFT, COMMIT.
- IDLE:
  - cfg_valid is ignored.
  - cfg_start → SHIFT; clears bit_cnt, word_cnt, cfg_err, err_word.
- SHIFT:
  - cfg_ready = 1.
  - Each cycle with cfg_valid = 1 shifts cfg_bit into the word register and increments bit_cnt.
  - cfg_valid = 0 stalls; no timeout.
- Word completion (bit_cnt reaches CFG_W-1 with cfg_valid) — the word is checked on that same edge:
  - Illegal side code (5..7) → error.
  - Side code 1/3 with index ≥ N_TB → error.
  - Side code 2/4 with index ≥ N_LR → error.
  - Self-route → error: side code equals the entry's own side and index equals its own pin (e.g. top[2] = code 1, index 2).
  - Side code 0: index field is ignored; the word is always legal.
- On a word error:
  - cfg_err <= 1, err_word <= word_cnt, state → IDLE.
  - cfg_out is unchanged (previous config retained).
- On a legal word:
  - Word is written to shadow[word_cnt]; word_cnt increments and bit_cnt clears.
  - If word_cnt == N_ENT-1 → COMMIT.
- COMMIT (exactly one cycle):
  - cfg_ready = 0.
  - Next edge: cfg_out <= shadow, cfg_done = 1 for the following cycle, state → IDLE.
- Latency: cfg_out updates 1 clk after the edge that accepts the final bit.
- cfg_start while in SHIFT or COMMIT restarts the load (→ SHIFT, counters cleared); no commit occurs. cfg_start has priority over a simultaneous cfg_valid.
- cfg_out changes only in COMMIT or on reset; a partial load is never visible.

Optional Feature:
- Macro: SWITCHBOX_CFG_PARITY_EN.
- Defined:
  - Each word is followed by one odd-parity bit (CFG_W+1 bits per word).
  - Parity failure → cfg_err, err_word = the failing entry, abort to IDLE.
  - The parity check is evaluated together with the route checks on the parity-bit edge.
- Undefined: CFG_W bits per word; no parity check.

Test Plan:
- Full legal load: reset, cfg_start, 18 words all 6'b010_100 except left/right entries 6'b001_001, cfg_valid continuous → cfg_done 1 clk after 108th bit; entry 0 reads 0x14; cfg_err = 0.
- Stalls: same stream with cfg_valid deasserted for 3 cycles every 5 bits → identical cfg_out; cfg_ready stays high throughout SHIFT.
- Illegal side: word 3 = 6'b000_101 → cfg_err = 1, err_word = 3, busy drops, cfg_out retains the prior load; following cfg_valid bits are ignored.
- Range and self-route errors:
  - Word 10 (left[0]) = 6'b100_100 (left[4]) → err_word = 10.
  - Separate run: word 2 = 6'b010_001 (self-route) → err_word = 2.
- Restart and reset:
  - cfg_start asserted after 40 bits, then a full load → single cfg_done, values from the second load only.
  - rst_n low mid-load → cfg_out = 0, all outputs 0.
- With SWITCHBOX_CFG_PARITY_EN: a wrong parity bit on word 0 → err_word = 0; a correct stream of 126 bits commits.

Source files
------------

// File: rtl/switchbox_cfg_loader_if.sv
// switchbox_cfg_loader_if
//   Bundles the serial load handshake and the committed configuration bus
//   between the device configuration controller (master) and the switch-box
//   configuration loader (slave).
//   cfg_start/cfg_valid/cfg_bit : controller -> loader serial route stream
//   cfg_ready/busy              : loader status
//   cfg_out                     : active per-pin route words, entry k at [k*CFG_W +: CFG_W]
//   cfg_done/cfg_err/err_word   : commit pulse, sticky error, first failing entry
interface switchbox_cfg_loader_if #(
    parameter int N_ENT = 18,
    parameter int CFG_W = 6
);
    logic                     cfg_start;
    logic                     cfg_valid;
    logic                     cfg_bit;
    logic                     cfg_ready;
    logic [N_ENT*CFG_W-1:0]   cfg_out;
    logic                     cfg_done;
    logic                     cfg_err;
    logic [4:0]               err_word;
    logic                     busy;

    modport master (
        output cfg_start, cfg_valid, cfg_bit,
        input  cfg_ready, cfg_out, cfg_done, cfg_err, err_word, busy
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_bit,
        output cfg_ready, cfg_out, cfg_done, cfg_err, err_word, busy
    );
endinterface

// File: rtl/switchbox_cfg_loader.sv
// switchbox_cfg_loader
//   Deserializes a bit-serial route stream (MSB first) into one route word
//   per switch-box pin, validates each word as it completes, and commits the
//   whole set atomically onto the flattened configuration bus.
//   Route word: [2:0] side code (0 undriven, 1 top, 2 right, 3 bottom,
//   4 left), [5:3] source index. Entry order: top, bottom, left, right.
//   Ports:
//     clk   : clock, rising edge
//     rst_n : synchronous active-low reset
//     bus   : switchbox_cfg_loader_if.slave (stream in, config/status out)
//   Optional build macro SWITCHBOX_CFG_PARITY_EN: every word is followed by
//   one odd-parity bit, checked together with the route checks.
module switchbox_cfg_loader #(
    parameter int N_TB  = 5,
    parameter int N_LR  = 4,
    parameter int CFG_W = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    switchbox_cfg_loader_if.slave   bus
);
    localparam int N_ENT = 2*N_TB + 2*N_LR;
`ifdef SWITCHBOX_CFG_PARITY_EN
    localparam int BITS = CFG_W + 1;
`else
    localparam int BITS = CFG_W;
`endif
    // Only BITS-1 bits need storing; the last one arrives on cfg_bit itself.
    localparam int SR_W = BITS - 1;
    localparam int BCW  = $clog2(BITS);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t                         state, state_nxt;
    logic [BCW-1:0]                 bit_cnt;
    logic [4:0]                     word_cnt;
    logic [SR_W-1:0]                word_sr;
    logic [N_ENT-1:0][CFG_W-1:0]    shadow;
    logic [N_ENT-1:0][CFG_W-1:0]    active;
    logic                           done_q, err_q;
    logic [4:0]                     err_word_q;
    logic                           ready_c, busy_c;

    logic [CFG_W-1:0]               cur_word;
    logic                           par_ok;
    logic [2:0]                     side, idx, own_side, own_pin;
    logic                           route_ok, self_route, word_ok, word_done;

`ifdef SWITCHBOX_CFG_PARITY_EN
    assign cur_word = word_sr;
    assign par_ok   = ^{word_sr, bus.cfg_bit};
`else
    assign cur_word = {word_sr, bus.cfg_bit};
    assign par_ok   = 1'b1;
`endif

    assign side = cur_word[2:0];
    assign idx  = cur_word[5:3];

    // Side and pin of the entry currently being loaded, for the self-route check.
    always_comb begin
        own_side = 3'd0;
        own_pin  = 3'd0;
        if (word_cnt < 5'(N_TB)) begin
            own_side = 3'd1;
            own_pin  = 3'(word_cnt);
        end else if (word_cnt < 5'(2*N_TB)) begin
            own_side = 3'd3;
            own_pin  = 3'(word_cnt - 5'(N_TB));
        end else if (word_cnt < 5'(2*N_TB + N_LR)) begin
            own_side = 3'd4;
            own_pin  = 3'(word_cnt - 5'(2*N_TB));
        end else begin
            own_side = 3'd2;
            own_pin  = 3'(word_cnt - 5'(2*N_TB + N_LR));
        end
    end

    always_comb begin
        case (side)
            3'd0:       route_ok = 1'b1;
            3'd1, 3'd3: route_ok = ({2'b00, idx} < 5'(N_TB));
            3'd2, 3'd4: route_ok = ({2'b00, idx} < 5'(N_LR));
            default:    route_ok = 1'b0;
        endcase
    end

    // Side code 0 never matches an own side (1..4), so undriven stays legal.
    assign self_route = (side == own_side) && (idx == own_pin);
    assign word_ok    = route_ok && !self_route && par_ok;
    assign word_done  = (state == SHIFT) && bus.cfg_valid && !bus.cfg_start &&
                        (bit_cnt == BCW'(BITS-1));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready_c   = 1'b0;
        busy_c    = 1'b1;
        case (state)
            IDLE: begin
                busy_c = 1'b0;
                if (bus.cfg_start) state_nxt = SHIFT;
            end
            SHIFT: begin
                ready_c = 1'b1;
                if (bus.cfg_start)                                  state_nxt = SHIFT;
                else if (word_done && !word_ok)                     state_nxt = IDLE;
                else if (word_done && word_cnt == 5'(N_ENT-1))      state_nxt = COMMIT;
            end
            COMMIT:  state_nxt = bus.cfg_start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt    <= '0;
            word_cnt   <= '0;
            word_sr    <= '0;
            shadow     <= '0;
            active     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_word_q <= '0;
        end else begin
            done_q <= 1'b0;
            // Start wins over everything, including a pending commit.
            if (bus.cfg_start) begin
                bit_cnt    <= '0;
                word_cnt   <= '0;
                err_q      <= 1'b0;
                err_word_q <= '0;
            end else if (state == SHIFT && bus.cfg_valid) begin
                word_sr <= {word_sr[SR_W-2:0], bus.cfg_bit};
                if (word_done) begin
                    bit_cnt <= '0;
                    if (word_ok) begin
                        shadow[word_cnt] <= cur_word;
                        word_cnt         <= word_cnt + 5'd1;
                    end else begin
                        err_q      <= 1'b1;
                        err_word_q <= word_cnt;
                    end
                end else begin
                    bit_cnt <= bit_cnt + BCW'(1);
                end
            end else if (state == COMMIT) begin
                active <= shadow;
                done_q <= 1'b1;
            end
        end
    end

    assign bus.cfg_ready = ready_c;
    assign bus.busy      = busy_c;
    assign bus.cfg_out   = active;
    assign bus.cfg_done  = done_q;
    assign bus.cfg_err   = err_q;
    assign bus.err_word  = err_word_q;
endmodule

// File: tb/tb_switchbox_cfg_loader.sv
// tb_switchbox_cfg_loader
//   Scoreboard bench for switchbox_cfg_loader: each load pushes its expected
//   outcome (commit value or error entry) and pops it when the loader reports
//   cfg_done or cfg_err.
module tb_switchbox_cfg_loader;
    localparam int N_ENT = 18;
    localparam int CFG_W = 6;
    localparam int OUT_W = N_ENT*CFG_W;

    typedef struct {
        bit               is_err;
        logic [4:0]       ew;
        logic [OUT_W-1:0] out;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    switchbox_cfg_loader_if #(.N_ENT(N_ENT), .CFG_W(CFG_W)) bus ();
    switchbox_cfg_loader dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    exp_t             sb[$];
    exp_t             e;
    logic [CFG_W-1:0] stim[N_ENT];
    logic [OUT_W-1:0] model_out;
    int chk_cnt = 0, pass_cnt = 0, done_cnt = 0;
    int bit_no, ready_drop, cyc, d0;
`ifdef SWITCHBOX_CFG_PARITY_EN
    int flip_word = -1;
`endif

    always @(negedge clk) if (bus.cfg_done === 1'b1) done_cnt++;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_bit(input logic b, input bit stall);
        bus.cfg_valid = 1'b1;
        bus.cfg_bit   = b;
        tick();
        bit_no++;
        if (stall && (bit_no % 5 == 0)) begin
            bus.cfg_valid = 1'b0;
            repeat (3) begin
                if (bus.cfg_ready !== 1'b1) ready_drop++;
                tick();
            end
        end
    endtask

    task automatic load(input int first, input int last, input bit with_start, input bit stall);
        if (with_start) begin
            bus.cfg_start = 1'b1;
            tick();
            bus.cfg_start = 1'b0;
        end
        for (int k = first; k <= last; k++) begin
            for (int i = CFG_W-1; i >= 0; i--) send_bit(stim[k][i], stall);
`ifdef SWITCHBOX_CFG_PARITY_EN
            send_bit((~^stim[k]) ^ (k == flip_word), stall);
`endif
        end
        bus.cfg_valid = 1'b0;
    endtask

    task automatic wait_result(input int budget);
        cyc = 0;
        while (bus.cfg_done !== 1'b1 && bus.cfg_err !== 1'b1 && cyc < budget) begin
            tick();
            cyc++;
        end
    endtask

    function automatic void fill_base();
        for (int k = 0; k < N_ENT; k++) stim[k] = (k >= 10) ? 6'b001_001 : 6'b010_100;
    endfunction

    function automatic void fill_b();
        for (int k = 0; k < N_ENT; k++) stim[k] = (k >= 10) ? 6'b100_001 : 6'b001_010;
    endfunction

    function automatic logic [OUT_W-1:0] pack_stim();
        logic [OUT_W-1:0] p;
        for (int k = 0; k < N_ENT; k++) p[k*CFG_W +: CFG_W] = stim[k];
        return p;
    endfunction

    task automatic test_reset();
        bus.cfg_start = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_bit = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick();
        chk_cnt++; if (bus.cfg_out !== '0) $display("FAIL reset_cfg_out got %h exp 0", bus.cfg_out); else pass_cnt++;
        chk_cnt++; if ({bus.cfg_ready, bus.cfg_done, bus.cfg_err, bus.busy, bus.err_word} !== 9'd0)
            $display("FAIL reset_status got rdy%b done%b err%b busy%b ew%0d exp all 0",
                     bus.cfg_ready, bus.cfg_done, bus.cfg_err, bus.busy, bus.err_word);
        else pass_cnt++;
        rst_n = 1'b1;
        tick();
        model_out = '0;
    endtask

    task automatic test_full_load();
        fill_base();
        sb.push_back('{0, 5'd0, pack_stim()});
        bit_no = 0;
        load(0, N_ENT-1, 1, 0);
        chk_cnt++; if ({bus.cfg_done, bus.busy, bus.cfg_ready} !== 3'b010)
            $display("FAIL commit_state got done%b busy%b rdy%b exp 0/1/0", bus.cfg_done, bus.busy, bus.cfg_ready);
        else pass_cnt++;
        wait_result(4);
        e = sb.pop_front();
        chk_cnt++; if (cyc !== 1 || bus.cfg_done !== 1'b1) $display("FAIL full_latency got %0d cycles done%b exp 1", cyc, bus.cfg_done); else pass_cnt++;
        chk_cnt++; if (bus.cfg_out !== e.out) $display("FAIL full_cfg_out got %h exp %h", bus.cfg_out, e.out); else pass_cnt++;
        chk_cnt++; if (bus.cfg_out[5:0] !== 6'h14) $display("FAIL full_entry0 got %h exp 14", bus.cfg_out[5:0]); else pass_cnt++;
        chk_cnt++; if (bus.cfg_out[17*CFG_W +: CFG_W] !== 6'b001_001) $display("FAIL full_entry17 got %h exp 09", bus.cfg_out[17*CFG_W +: CFG_W]); else pass_cnt++;
        chk_cnt++; if (bus.cfg_err !== e.is_err) $display("FAIL full_err got %b exp %b", bus.cfg_err, e.is_err); else pass_cnt++;
        model_out = e.out;
        tick();
        chk_cnt++; if (bus.cfg_done !== 1'b0 || bus.busy !== 1'b0) $display("FAIL full_done_pulse got done%b busy%b exp 0/0", bus.cfg_done, bus.busy); else pass_cnt++;
    endtask

    task automatic test_stalls();
        fill_base();
        sb.push_back('{0, 5'd0, pack_stim()});
        bit_no = 0; ready_drop = 0; d0 = done_cnt;
        load(0, N_ENT-1, 1, 1);
        wait_result(4);
        e = sb.pop_front();
        chk_cnt++; if (bus.cfg_out !== e.out || cyc !== 1) $display("FAIL stall_cfg_out got %h after %0d cycles exp %h after 1", bus.cfg_out, cyc, e.out); else pass_cnt++;
        chk_cnt++; if (ready_drop !== 0) $display("FAIL stall_ready got %0d low samples exp 0", ready_drop); else pass_cnt++;
        tick();
        chk_cnt++; if (done_cnt - d0 !== 1) $display("FAIL stall_done_count got %0d exp 1", done_cnt - d0); else pass_cnt++;
        model_out = e.out;
    endtask

    task automatic test_illegal_side();
        fill_b();
        stim[3] = 6'b000_101;
        sb.push_back('{1, 5'd3, model_out});
        bit_no = 0; d0 = done_cnt;
        load(0, 3, 1, 0);
        wait_result(4);
        e = sb.pop_front();
        chk_cnt++; if (bus.cfg_err !== e.is_err || bus.err_word !== e.ew || cyc !== 0)
            $display("FAIL illegal_err got err%b ew%0d after %0d cycles exp err1 ew%0d after 0", bus.cfg_err, bus.err_word, cyc, e.ew);
        else pass_cnt++;
        chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL illegal_busy got %b exp 0", bus.busy); else pass_cnt++;
        // remaining bits stream in while idle and must be ignored
        load(4, N_ENT-1, 0, 0);
        repeat (3) tick();
        chk_cnt++; if (bus.cfg_out !== e.out) $display("FAIL illegal_retain got %h exp %h", bus.cfg_out, e.out); else pass_cnt++;
        chk_cnt++; if (done_cnt !== d0 || bus.err_word !== 5'd3 || bus.cfg_err !== 1'b1)
            $display("FAIL illegal_ignore got done_pulses %0d ew%0d err%b exp 0/3/1", done_cnt - d0, bus.err_word, bus.cfg_err);
        else pass_cnt++;
    endtask

    task automatic test_range_err();
        fill_base();
        stim[10] = 6'b100_100;
        sb.push_back('{1, 5'd10, model_out});
        bus.cfg_start = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
        chk_cnt++; if (bus.cfg_err !== 1'b0 || bus.err_word !== 5'd0) $display("FAIL start_clears_err got err%b ew%0d exp 0/0", bus.cfg_err, bus.err_word); else pass_cnt++;
        load(0, N_ENT-1, 0, 0);
        wait_result(4);
        e = sb.pop_front();
        chk_cnt++; if (bus.cfg_err !== 1'b1 || bus.err_word !== e.ew) $display("FAIL range_err got err%b ew%0d exp 1/%0d", bus.cfg_err, bus.err_word, e.ew); else pass_cnt++;
        chk_cnt++; if (bus.cfg_out !== e.out) $display("FAIL range_retain got %h exp %h", bus.cfg_out, e.out); else pass_cnt++;
    endtask

    task automatic test_self_route();
        fill_base();
        stim[2] = 6'b010_001;
        sb.push_back('{1, 5'd2, model_out});
        load(0, N_ENT-1, 1, 0);
        wait_result(4);
        e = sb.pop_front();
        chk_cnt++; if (bus.cfg_err !== 1'b1 || bus.err_word !== e.ew) $display("FAIL self_route_err got err%b ew%0d exp 1/%0d", bus.cfg_err, bus.err_word, e.ew); else pass_cnt++;
    endtask

    task automatic test_restart();
        for (int k = 0; k < N_ENT; k++) stim[k] = 6'b010_011;
        d0 = done_cnt;
        load(0, 5, 1, 0);
        for (int i = CFG_W-1; i >= 2; i--) send_bit(stim[6][i], 0);
        // restart with a simultaneous valid bit that must be dropped
        bus.cfg_start = 1'b1; bus.cfg_valid = 1'b1; bus.cfg_bit = 1'b1;
        tick();
        bus.cfg_start = 1'b0; bus.cfg_valid = 1'b0;
        fill_b();
        sb.push_back('{0, 5'd0, pack_stim()});
        load(0, N_ENT-1, 0, 0);
        wait_result(4);
        e = sb.pop_front();
        chk_cnt++; if (bus.cfg_out !== e.out || bus.cfg_done !== 1'b1) $display("FAIL restart_cfg_out got %h done%b exp %h done1", bus.cfg_out, bus.cfg_done, e.out); else pass_cnt++;
        tick();
        chk_cnt++; if (done_cnt - d0 !== 1) $display("FAIL restart_done_count got %0d exp 1", done_cnt - d0); else pass_cnt++;
        model_out = e.out;
    endtask

    task automatic test_mid_reset();
        fill_base();
        load(0, 4, 1, 0);
        bus.cfg_valid = 1'b1; bus.cfg_bit = 1'b1;
        rst_n = 1'b0;
        tick();
        chk_cnt++; if (bus.cfg_out !== '0) $display("FAIL midreset_cfg_out got %h exp 0", bus.cfg_out); else pass_cnt++;
        chk_cnt++; if ({bus.cfg_ready, bus.cfg_done, bus.cfg_err, bus.busy, bus.err_word} !== 9'd0)
            $display("FAIL midreset_status got rdy%b done%b err%b busy%b ew%0d exp all 0",
                     bus.cfg_ready, bus.cfg_done, bus.cfg_err, bus.busy, bus.err_word);
        else pass_cnt++;
        rst_n = 1'b1; bus.cfg_valid = 1'b0;
        tick();
        model_out = '0;
    endtask

`ifdef SWITCHBOX_CFG_PARITY_EN
    task automatic test_parity();
        fill_base();
        flip_word = 0;
        sb.push_back('{1, 5'd0, model_out});
        load(0, N_ENT-1, 1, 0);
        wait_result(4);
        e = sb.pop_front();
        chk_cnt++; if (bus.cfg_err !== 1'b1 || bus.err_word !== e.ew || bus.cfg_out !== e.out)
            $display("FAIL parity_err got err%b ew%0d exp 1/%0d", bus.cfg_err, bus.err_word, e.ew);
        else pass_cnt++;
        flip_word = -1;
        sb.push_back('{0, 5'd0, pack_stim()});
        bit_no = 0;
        load(0, N_ENT-1, 1, 0);
        wait_result(4);
        e = sb.pop_front();
        chk_cnt++; if (bus.cfg_out !== e.out || cyc !== 1 || bit_no !== 126)
            $display("FAIL parity_commit got %h after %0d cycles %0d bits exp %h after 1, 126 bits", bus.cfg_out, cyc, bit_no, e.out);
        else pass_cnt++;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_full_load();
        test_stalls();
        test_illegal_side();
        test_range_err();
        test_self_route();
        test_restart();
        test_mid_reset();
`ifdef SWITCHBOX_CFG_PARITY_EN
        test_parity();
`endif
        chk_cnt++; if (sb.size() !== 0) $display("FAIL scoreboard_drain got %0d left exp 0", sb.size()); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
